fifo_param: RTL

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parameterised synchronous circular-buffer FIFO with level and sticky error flags
module fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in,
    input  logic                     write_en,
    input  logic                     read_en,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic rd_ok, wr_ok, rd_go, wr_go, ovf_evt, udf_evt, mem_we;

    // Next-state: accept/reject decisions, pointer/count update, flush and reset overrides, flags from the new count
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        // A read frees a slot in the same edge, so a full FIFO can still take a write alongside it.
        rd_ok   = read_en && !empty_q;
        wr_ok   = write_en && (!full_q || rd_ok);
        rd_go   = rd_ok && !flush;
        wr_go   = wr_ok && !flush;
        ovf_evt = !flush && write_en && !wr_ok;
        udf_evt = !flush && read_en && !rd_ok;

        // Clear first so an error in the same cycle leaves the flag set.
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (ovf_evt) ovf_d = 1'b1;
        if (udf_evt) udf_d = 1'b1;

        if (rd_go) begin
            out_d  = mem[rptr_q];
            rptr_d = rptr_q + AW'(1);
        end
        if (wr_go) begin
            wptr_d = wptr_q + AW'(1);
        end

        case ({wr_go, rd_go})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flush only rewinds pointers; stored words stay in the array.
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end

        if (rst) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            out_d   = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end

        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CW'(AFULL_TH));
        aempty_d = (count_d <= CW'(AEMPTY_TH));

        mem_we   = wr_go && !rst;
    end

    // State registers with synchronous active-high reset folded into the next-state logic
    always_ff @(posedge clk) begin
        wptr_q   <= wptr_d;
        rptr_q   <= rptr_d;
        count_q  <= count_d;
        out_q    <= out_d;
        full_q   <= full_d;
        empty_q  <= empty_d;
        afull_q  <= afull_d;
        aempty_q <= aempty_d;
        ovf_q    <= ovf_d;
        udf_q    <= udf_d;
    end

    // Storage array write port; no reset on the array itself
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= in;
        end
    end

    assign out          = out_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
